// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: mode encoding and divider terminal counts.
// The divider imports the same terminal counts so both sides agree on the tick cycle.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'b00,
    RUN    = 2'b01,
    ADJUST = 2'b10
  } state_t;

  localparam int CNT1_W   = 27;
  localparam int CNTADJ_W = 26;

  localparam logic [CNT1_W-1:0]   ONE_HZ_TERM_DEF = 27'd99_999_999;
  localparam logic [CNTADJ_W-1:0] ADJ_TERM_DEF    = 26'd19_999_999;

  // The ones digit wraps on 9 and the tens digit on 5, so a field reads 00..59.
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  function automatic logic at_max(input logic [3:0] tens, input logic [3:0] ones);
    return (tens == TENS_MAX) && (ones == ONES_MAX);
  endfunction

endpackage

// File: rtl/bcd60_counter.sv
// Two-digit BCD counter that runs 00..59 and wraps; used for both seconds and minutes.
// carry flags the increment that wraps 59 back to 00.
module bcd60_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic [3:0] tens_q;
  logic [3:0] ones_q;

  // Out-of-range digits are treated as terminal so they can never persist.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (inc) begin
      if (ones_q >= ONES_MAX) begin
        ones_q <= 4'd0;
        if (tens_q >= TENS_MAX) begin
          tens_q <= 4'd0;
        end else begin
          tens_q <= tens_q + 4'd1;
        end
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign carry = inc && at_max(tens_q, ones_q);
  assign tens  = tens_q;
  assign ones  = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time-keeping core: tick decode, run/pause/adjust mode FSM and the MM:SS
// BCD counters that feed the seven-segment driver.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter logic [CNT1_W-1:0]   ONE_HZ_TERM = ONE_HZ_TERM_DEF,
  parameter logic [CNTADJ_W-1:0] ADJ_TERM    = ADJ_TERM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT1_W-1:0]   cnt1,
  input  logic [CNTADJ_W-1:0] cntadj,
  input  logic                pause_p,
  input  logic                clr_p,
  input  logic                adj,
  input  logic                sel,
  output logic [3:0]          min_t,
  output logic [3:0]          min_o,
  output logic [3:0]          sec_t,
  output logic [3:0]          sec_o,
  output logic [1:0]          state
);

  state_t state_q;
  state_t state_d;

  logic tick1;
  logic tickadj;
  logic sec_inc;
  logic min_inc;
  logic sec_carry;
  logic min_carry_unused;

  // The divider holds each terminal value for exactly one cycle, so a plain compare is the tick.
  assign tick1   = (cnt1 == ONE_HZ_TERM);
  assign tickadj = (cntadj == ADJ_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving ADJUST always lands in PAUSED so a released adj never starts the clock by itself.
  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ADJUST;
    end else begin
      case (state_q)
        PAUSED:  if (pause_p) state_d = RUN;
        RUN:     if (pause_p) state_d = PAUSED;
        ADJUST:  state_d = PAUSED;
        default: state_d = PAUSED;
      endcase
    end
  end

  // Increments follow the mode held at the start of the cycle, not the one being entered.
  always_comb begin
    sec_inc = 1'b0;
    min_inc = 1'b0;
    case (state_q)
      RUN: begin
        sec_inc = tick1;
        min_inc = sec_carry;
      end
      ADJUST: begin
        sec_inc = tickadj & sel;
        min_inc = tickadj & ~sel;
      end
      default: begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
      end
    endcase
  end

  bcd60_counter u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (clr_p),
    .tens  (sec_t),
    .ones  (sec_o),
    .carry (sec_carry)
  );

  bcd60_counter u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (clr_p),
    .tens  (min_t),
    .ones  (min_o),
    .carry (min_carry_unused)
  );

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with shortened terminal counts (9 and 3) and a
// wrapping model of the divider count buses.
module tb_stopwatch_core;

  localparam logic [26:0] T1   = 27'd9;
  localparam logic [25:0] TADJ = 26'd3;
  localparam int          WAIT_BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] cnt1;
  logic [25:0] cntadj;
  logic        pause_p;
  logic        clr_p;
  logic        adj;
  logic        sel;
  logic [3:0]  min_t;
  logic [3:0]  min_o;
  logic [3:0]  sec_t;
  logic [3:0]  sec_o;
  logic [1:0]  state;

  logic en1;
  logic enadj;
  int   checks   = 0;
  int   failures = 0;

  stopwatch_core #(
    .ONE_HZ_TERM (T1),
    .ADJ_TERM    (TADJ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt1    (cnt1),
    .cntadj  (cntadj),
    .pause_p (pause_p),
    .clr_p   (clr_p),
    .adj     (adj),
    .sel     (sel),
    .min_t   (min_t),
    .min_o   (min_o),
    .sec_t   (sec_t),
    .sec_o   (sec_o),
    .state   (state)
  );

  always #5 clk = ~clk;

  // One clock, then advance the divider model; inputs change 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (en1) cnt1 = (cnt1 == T1) ? 27'd0 : cnt1 + 27'd1;
    if (enadj) cntadj = (cntadj == TADJ) ? 26'd0 : cntadj + 26'd1;
  endtask

  task automatic applyStimulus(input logic p, input logic c, input logic a, input logic s);
    pause_p = p;
    clr_p   = c;
    adj     = a;
    sel     = s;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_time,
                             input logic [1:0] exp_state);
    logic [17:0] obs;
    logic [17:0] expv;
    obs  = {min_t, min_o, sec_t, sec_o, state};
    expv = {exp_time, exp_state};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: got %h:%h state=%b, expected %h:%h state=%b", tag,
             obs[17:10], obs[9:2], obs[1:0], expv[17:10], expv[9:2], expv[1:0]);
    end
  endtask

  task automatic waitTick1();
    int n = 0;
    while (cnt1 != T1) begin
      cycle();
      n++;
      if (n > WAIT_BUDGET) begin
        failures++;
        $display("[TB] FAIL wait_tick1: no cnt1 terminal within %0d cycles", WAIT_BUDGET);
        break;
      end
    end
  endtask

  task automatic waitTickAdj();
    int n = 0;
    while (cntadj != TADJ) begin
      cycle();
      n++;
      if (n > WAIT_BUDGET) begin
        failures++;
        $display("[TB] FAIL wait_tickadj: no cntadj terminal within %0d cycles", WAIT_BUDGET);
        break;
      end
    end
  endtask

  task automatic adjTicks(input int count);
    repeat (count) begin
      waitTickAdj();
      cycle();
    end
  endtask

  task automatic pulsePause();
    applyStimulus(1'b1, 1'b0, adj, sel);
    cycle();
    applyStimulus(1'b0, 1'b0, adj, sel);
  endtask

  initial begin
    rst = 1'b1;
    cnt1 = 27'd0;
    cntadj = 26'd0;
    en1 = 1'b0;
    enadj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("reset", 16'h0000, 2'b00);

    // Run ten seconds; each update lands on the edge that ends the cnt1==9 cycle.
    pulsePause();
    checkOutput("run_entry", 16'h0000, 2'b01);
    en1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      waitTick1();
      checkOutput("pre_tick", {8'h00, 4'(( i - 1) / 10), 4'((i - 1) % 10)}, 2'b01);
      cycle();
      checkOutput("post_tick", {8'h00, 4'(i / 10), 4'(i % 10)}, 2'b01);
    end
    en1 = 1'b0;
    cnt1 = 27'd0;

    // Clear in RUN keeps the mode; then preload 59:58 through adjust.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_run", 16'h0000, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("adj_entry", 16'h0000, 2'b10);
    enadj = 1'b1;
    adjTicks(59);
    checkOutput("adj_min59", 16'h5900, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    adjTicks(58);
    checkOutput("adj_sec58", 16'h5958, 2'b10);
    enadj = 1'b0;
    cntadj = 26'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("adj_exit", 16'h5958, 2'b00);
    pulsePause();
    en1 = 1'b1;
    waitTick1();
    cycle();
    checkOutput("wrap_5959", 16'h5959, 2'b01);
    cycle();
    checkOutput("hold_5959", 16'h5959, 2'b01);
    waitTick1();
    cycle();
    checkOutput("wrap_0000", 16'h0000, 2'b01);
    en1 = 1'b0;
    cnt1 = 27'd0;

    // Seconds adjust wraps 59->00 without touching minutes.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    enadj = 1'b1;
    adjTicks(57);
    checkOutput("adj_0057", 16'h0057, 2'b10);
    adjTicks(1);
    checkOutput("adj_0058", 16'h0058, 2'b10);
    adjTicks(1);
    checkOutput("adj_0059", 16'h0059, 2'b10);
    adjTicks(1);
    checkOutput("adj_0000", 16'h0000, 2'b10);
    adjTicks(1);
    checkOutput("adj_0001", 16'h0001, 2'b10);
    pulsePause();
    checkOutput("adj_pause_ignored", 16'h0001, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    adjTicks(12);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    adjTicks(33);
    checkOutput("adj_1234", 16'h1234, 2'b10);
    enadj = 1'b0;
    cntadj = 26'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("adj_fall_paused", 16'h1234, 2'b00);

    // Clear wins over a coincident tick.
    pulsePause();
    en1 = 1'b1;
    waitTick1();
    checkOutput("pre_clr", 16'h1234, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_vs_tick", 16'h0000, 2'b01);

    // Pause coincident with a tick: the second still counts, then time holds.
    repeat (5) begin
      waitTick1();
      cycle();
    end
    checkOutput("run_0005", 16'h0005, 2'b01);
    waitTick1();
    pulsePause();
    checkOutput("pause_vs_tick", 16'h0006, 2'b00);
    repeat (2) begin
      waitTick1();
      cycle();
    end
    checkOutput("paused_hold", 16'h0006, 2'b00);
    en1 = 1'b0;
    cnt1 = 27'd0;

    // Reset coincident with a tick at 03:21.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    enadj = 1'b1;
    adjTicks(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    adjTicks(15);
    enadj = 1'b0;
    cntadj = 26'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    pulsePause();
    checkOutput("run_0321", 16'h0321, 2'b01);
    en1 = 1'b1;
    waitTick1();
    rst = 1'b1;
    cycle();
    checkOutput("rst_vs_tick", 16'h0000, 2'b00);
    waitTick1();
    cycle();
    checkOutput("rst_held", 16'h0000, 2'b00);
    rst = 1'b0;
    cycle();
    checkOutput("rst_release", 16'h0000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Time-keeping core of the stopwatch: turns the free-running divider counts into one-cycle ticks and keeps an MM:SS value as four BCD digits. It sits directly downstream of the clock divider. It consumes the 1 Hz and 5 Hz (adjust) count buses and feeds the seven-segment display driver. It owns the run/pause/adjust mode state machine.

## Interface
- ONE_HZ_TERM, 99_999_999: value of the 1 Hz count bus on its last cycle before wrap.
- ADJ_TERM, 19_999_999: value of the 5 Hz adjust count bus on its last cycle before wrap.
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- cnt1  in  27  1 Hz divider count; it holds ONE_HZ_TERM for exactly one cycle per period.
- cntadj  in  26  5 Hz divider count; it holds ADJ_TERM for exactly one cycle per period.
- pause_p  in  1  one-cycle pulse from the debounced pause button.
- clr_p  in  1  one-cycle pulse from the debounced reset button. This is a time clear, not a logic reset.
- adj  in  1  level input; 1 selects adjust mode.
- sel  in  1  field select in adjust mode: 0 = minutes, 1 = seconds.
- min_t, min_o, sec_t, sec_o  out  4 each  BCD digits. Tens digits range 0–5; ones digits range 0–9.
- state  out  2  current mode: 00 PAUSED, 01 RUN, 10 ADJUST.

## Operation
- Tick generation:
  - tick1 = (cnt1 == ONE_HZ_TERM).
  - tickadj = (cntadj == ADJ_TERM).
  - Both are combinational, one cycle wide, and need no edge detection.
- States:
  - PAUSED: the time holds. pause_p moves to RUN.
  - RUN: on tick1 the time advances one second. pause_p moves to PAUSED.
  - ADJUST: on tickadj the selected field increments modulo 60, with no carry into the other field. pause_p is ignored.
  - adj=1 forces ADJUST from any state. adj falling returns to PAUSED, never directly to RUN.
- Seconds advance:
  - sec_o counts 9→0 and carries into sec_t.
  - sec_t counts 5→0 and carries into minutes.
  - The minutes field wraps identically.
  - 59:59 + 1 → 00:00, with no overflow flag.
- Adjust increment: the selected field goes 59→00. The other field is untouched.
- clr_p sets all digits to 0 in any state and leaves the state unchanged.
- Priority within one cycle, highest first: rst > clr_p > tick-driven increment.
  - The state transition and a time update may occur in the same cycle.
  - Mode changes take effect from the next cycle.
  - The tick is evaluated against the state held at the start of the cycle.
- A change of sel mid-ADJUST applies from the next tickadj. An increment in progress is never split.
- Digits never hold an illegal BCD value, including just after reset.

## Timing
- Reset values: all four digits 0; state = PAUSED (00).
- Reset mid-count: digits are cleared at the next edge, and a tick in the same cycle is discarded.
- Latency: tick in cycle N → digits updated at the clock edge ending cycle N, visible in N+1.
- pause_p or adj change in cycle N → the state output changes in N+1.
- A tick in cycle N uses the pre-transition state.
- All outputs are registered; there is no combinational input→output path.
- Simultaneous pause_p (RUN→PAUSED) and tick1 in the same cycle: the second still counts.

## Structure
- Package stopwatch_pkg holds:
  - the 2-bit state encoding constants PAUSED/RUN/ADJUST;
  - the default terminal-count constants, shared with the divider so both sides agree.
- One sub-module, bcd60_counter, is instantiated twice (seconds, minutes):
  - Inputs: inc, clr.
  - Outputs: tens[3:0], ones[3:0], carry.
  - carry is combinational, high when inc is high and the value is 59.
- The minutes instance's inc is:
  - in RUN: the seconds carry;
  - in ADJUST: tickadj & ~sel.
- The seconds instance's inc is:
  - in RUN: tick1;
  - in ADJUST: tickadj & sel.
- The FSM and the tick compares live in the top module.

## Test plan
All benches run with ONE_HZ_TERM=9 and ADJ_TERM=3, and a counter model that wraps the count buses.
1. Reset, pause_p, then 10 tick1 periods → state=01 and digits 00:10; the update lands one cycle after each cnt1==9.
2. Preload 59:58 via adjust, pause_p to RUN, then 2 ticks → 59:59 then 00:00, with no glitch digit.
3. adj=1, sel=1 from 00:57, then 4 tickadj → seconds 58, 59, 00, 01, minutes stay 00; adj=0 → state=00 (PAUSED).
4. clr_p asserted on the same cycle as tick1 in RUN at 12:34 → 00:00 next cycle, not 00:01; state stays 01.
5. pause_p coincident with tick1 in RUN at 00:05 → 00:06 and state=00; further ticks do not change the digits.
6. rst asserted mid-RUN at 03:21, coincident with tick1 → 00:00, state=00; tick1 ignored while rst is high.
